// File: rtl/memory_dma_initiator.sv
// Second bus master for the word-addressed data memory: copies or fills a block of
// aligned words, one access per cycle, with alignment/bounds rejection and abort.
module memory_dma_initiator #(
  parameter int LEN_WIDTH   = 16,
  parameter int MEMORY_SIZE = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic [31:0]          fill_value,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 memory_read,
  output logic                 memory_write,
  output logic [2:0]           option,
  output logic [31:0]          address,
  output logic [31:0]          write_data,
  input  logic [31:0]          read_data,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEMORY_SIZE);

  state_t               r_state;
  logic [31:0]          r_src_ptr;
  logic [31:0]          r_dst_ptr;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 r_mode;
  logic [31:0]          r_fill;
  logic [31:0]          r_data;
  logic [LEN_WIDTH-1:0] r_words_done;

  // End-of-block addresses are formed 33 bits wide so a huge length cannot wrap past the limit.
  logic [32:0] w_len_bytes;
  logic [32:0] w_src_end;
  logic [32:0] w_dst_end;
  logic        w_src_ok;
  logic        w_dst_ok;
  logic        w_req_ok;

  assign w_len_bytes = {{(33-LEN_WIDTH-2){1'b0}}, length, 2'b00};
  assign w_src_end   = {1'b0, src_addr} + w_len_bytes;
  assign w_dst_end   = {1'b0, dst_addr} + w_len_bytes;
  assign w_src_ok    = (src_addr[1:0] == 2'b00) && (w_src_end <= MEM_LIMIT);
  assign w_dst_ok    = (dst_addr[1:0] == 2'b00) && (w_dst_end <= MEM_LIMIT);
  assign w_req_ok    = w_dst_ok && (mode || w_src_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_remaining  <= '0;
      r_mode       <= 1'b0;
      r_fill       <= '0;
      r_data       <= '0;
      r_words_done <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_ptr    <= src_addr;
            r_dst_ptr    <= dst_addr;
            r_remaining  <= length;
            r_mode       <= mode;
            r_fill       <= fill_value;
            r_words_done <= '0;
            if (!w_req_ok)              r_state <= S_ERR;
            else if (length == '0)      r_state <= S_DONE;
            else if (!mode)             r_state <= S_READ;
            else                        r_state <= S_WRITE;
          end
        end
        S_READ: begin
          r_data    <= read_data;
          r_src_ptr <= r_src_ptr + 32'd4;
          r_state   <= abort ? S_DONE : S_WRITE;
        end
        S_WRITE: begin
          // The write presented this cycle always commits, even when aborting.
          r_dst_ptr    <= r_dst_ptr + 32'd4;
          r_words_done <= r_words_done + 1'b1;
          r_remaining  <= r_remaining - 1'b1;
          if (abort || (r_remaining == LEN_WIDTH'(1))) r_state <= S_DONE;
          else if (r_mode)                             r_state <= S_WRITE;
          else                                         r_state <= S_READ;
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus and status outputs are pure decodes of registered state and pointers.
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE) || (r_state == S_ERR);
  assign error        = (r_state == S_ERR);
  assign words_done   = r_words_done;
  assign memory_read  = (r_state == S_READ) || (r_state == S_WRITE);
  assign memory_write = (r_state == S_WRITE);
  assign option       = 3'b010;
  assign address      = (r_state == S_READ)  ? r_src_ptr :
                        (r_state == S_WRITE) ? r_dst_ptr : 32'd0;
  assign write_data   = (r_state != S_WRITE) ? 32'd0 :
                        (r_mode ? r_fill : r_data);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_memory_dma_initiator.sv
// Directed bench for memory_dma_initiator with a 4 KiB word memory model and
// per-step immediate assertions.
module tb_memory_dma_initiator;

  localparam int LW = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          mode;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [LW-1:0] length;
  logic [31:0]   fill_value;
  logic          abort;
  logic          busy;
  logic          done;
  logic          error;
  logic [LW-1:0] words_done;
  logic          memory_read;
  logic          memory_write;
  logic [2:0]    option;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic [2:0]    dbg_state;

  logic [31:0] mem [0:1023];
  int checks;
  int errors;
  int wr_cnt;
  int rd_only_cnt;
  int acc_cnt;

  memory_dma_initiator #(.LEN_WIDTH(LW), .MEMORY_SIZE(4096)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .error(error), .words_done(words_done), .memory_read(memory_read),
    .memory_write(memory_write), .option(option), .address(address),
    .write_data(write_data), .read_data(read_data), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data = mem[address[11:2]];

  // Memory model: preload, then commit writes on the rising edge.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4; i++)    mem[(32'h100 >> 2) + i] = 32'hA000_0000 + i;
    for (int i = 0; i < 8; i++)    mem[(32'h300 >> 2) + i] = 32'h3000_0000 + i;
    forever begin
      @(posedge clk);
      if (memory_write === 1'b1) mem[address[11:2]] <= write_data;
    end
  end

  // Bus activity counters, sampled mid-cycle.
  initial begin
    wr_cnt = 0; rd_only_cnt = 0; acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (memory_write === 1'b1) wr_cnt++;
      if (memory_read === 1'b1 && memory_write !== 1'b1) rd_only_cnt++;
      if (memory_read === 1'b1 || memory_write === 1'b1) acc_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [LW-1:0] n, input logic [31:0] f);
    @(posedge clk); #1;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the start edge (cycle 1); returns the cycle in which done was seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (cyc >= 100) begin
        cyc = -1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  int cyc;
  int s_wr, s_rd, s_acc;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0; abort = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mrd", 32'(memory_read), 32'd0);
    chk("rst_mwr", 32'(memory_write), 32'd0);
    chk("rst_option", 32'(option), 32'd2);
    chk("rst_address", address, 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Copy 4 words 0x100 -> 0x200
    s_wr = wr_cnt;
    start_req(1'b0, 32'h100, 32'h200, 16'd4, 32'h0);
    wait_done(cyc);
    chk("copy_latency", 32'(cyc), 32'd9);
    chk("copy_error", 32'(error), 32'd0);
    chk("copy_words", 32'(words_done), 32'd4);
    chk("copy_wr_count", 32'(wr_cnt - s_wr), 32'd4);
    chk("copy_m0", mem[32'h200 >> 2], 32'hA000_0000);
    chk("copy_m1", mem[(32'h200 >> 2) + 1], 32'hA000_0001);
    chk("copy_m2", mem[(32'h200 >> 2) + 2], 32'hA000_0002);
    chk("copy_m3", mem[(32'h200 >> 2) + 3], 32'hA000_0003);
    chk("copy_m4_untouched", mem[(32'h200 >> 2) + 4], 32'h0);

    // Fill 3 words at 0x40
    s_rd = rd_only_cnt;
    start_req(1'b1, 32'h0, 32'h40, 16'd3, 32'hDEADBEEF);
    wait_done(cyc);
    chk("fill_latency", 32'(cyc), 32'd4);
    chk("fill_error", 32'(error), 32'd0);
    chk("fill_words", 32'(words_done), 32'd3);
    chk("fill_no_read_state", 32'(rd_only_cnt - s_rd), 32'd0);
    chk("fill_m0", mem[32'h40 >> 2], 32'hDEADBEEF);
    chk("fill_m1", mem[(32'h40 >> 2) + 1], 32'hDEADBEEF);
    chk("fill_m2", mem[(32'h40 >> 2) + 2], 32'hDEADBEEF);
    chk("fill_m3_untouched", mem[(32'h40 >> 2) + 3], 32'h0);

    // Length zero
    s_acc = acc_cnt;
    start_req(1'b0, 32'h100, 32'h280, 16'd0, 32'h0);
    wait_done(cyc);
    chk("len0_latency", 32'(cyc), 32'd1);
    chk("len0_error", 32'(error), 32'd0);
    chk("len0_words", 32'(words_done), 32'd0);
    chk("len0_no_access", 32'(acc_cnt - s_acc), 32'd0);

    // Unaligned destination
    s_acc = acc_cnt;
    start_req(1'b0, 32'h100, 32'h202, 16'd1, 32'h0);
    wait_done(cyc);
    chk("unal_latency", 32'(cyc), 32'd1);
    chk("unal_error", 32'(error), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("unal_error_drops", 32'(error), 32'd0);
    chk("unal_no_access", 32'(acc_cnt - s_acc), 32'd0);

    // Bounds: 0xFFC + 8 > 4096 rejected, 0xFF8 + 8 == 4096 accepted
    s_acc = acc_cnt;
    start_req(1'b1, 32'h0, 32'hFFC, 16'd2, 32'h1234_5678);
    wait_done(cyc);
    chk("oob_latency", 32'(cyc), 32'd1);
    chk("oob_error", 32'(error), 32'd1);
    chk("oob_no_access", 32'(acc_cnt - s_acc), 32'd0);
    start_req(1'b1, 32'h0, 32'hFF8, 16'd2, 32'h1234_5678);
    wait_done(cyc);
    chk("edge_latency", 32'(cyc), 32'd3);
    chk("edge_error", 32'(error), 32'd0);
    chk("edge_m0", mem[32'hFF8 >> 2], 32'h1234_5678);
    chk("edge_m1", mem[32'hFFC >> 2], 32'h1234_5678);

    // Abort during the 2nd WRITE of a length-8 copy 0x300 -> 0x400
    start_req(1'b0, 32'h300, 32'h400, 16'd8, 32'h0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_mwr", 32'(memory_write), 32'd1);
    chk("abort_addr", address, 32'h404);
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(cyc);
    chk("abort_latency", 32'(cyc), 32'd1);
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_words", 32'(words_done), 32'd2);
    chk("abort_m0", mem[32'h400 >> 2], 32'h3000_0000);
    chk("abort_m1", mem[(32'h400 >> 2) + 1], 32'h3000_0001);
    chk("abort_m2_untouched", mem[(32'h400 >> 2) + 2], 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);

    // Start while busy is ignored; reset mid-copy stops all access
    start_req(1'b0, 32'h100, 32'h700, 16'd8, 32'h0);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; dst_addr = 32'h600; length = 16'd1; fill_value = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_mid_copy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s_wr = wr_cnt;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_words", 32'(words_done), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_no_writes", 32'(wr_cnt - s_wr), 32'd0);
    chk("rst_mid_m0", mem[32'h700 >> 2], 32'hA000_0000);
    chk("rst_mid_m1", mem[(32'h700 >> 2) + 1], 32'hA000_0001);
    chk("rst_mid_m2_untouched", mem[(32'h700 >> 2) + 2], 32'h0);
    chk("busy_start_ignored", mem[32'h600 >> 2], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
